// File: rtl/lif_pkg.sv
// Shared types and constants for the LIF neuron spike logger: voltage format, timestamp width, FSM encoding.
// No logic; the voltage is signed (1,6,9) fixed point.
package lif_pkg;
  localparam int V_W         = 16;
  localparam int V_INT_BITS  = 6;
  localparam int V_FRAC_BITS = 9;
  localparam int TS_W        = 16;
  localparam int EV_W        = TS_W + V_W;
  localparam int RATE_W      = 8;
  localparam int WCNT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } lif_state_t;

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [V_W-1:0]  vpre;
  } spike_ev_t;

  function automatic logic [RATE_W-1:0] sat_rate(input logic [WCNT_W:0] n);
    return (n > (WCNT_W+1)'(2**RATE_W - 1)) ? '1 : n[RATE_W-1:0];
  endfunction
endpackage

// File: rtl/spike_event_fifo.sv
// First-word-fall-through event FIFO: pushed entry is visible at the head one cycle after the push edge.
// Push when full is refused unless a pop happens in the same cycle; head reads zero when empty.
module spike_event_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/lif_spike_logger.sv
// Logs neuron spikes as {timestamp, pre-spike voltage} events into a FWFT FIFO and measures spike rate per window.
// Events visible one cycle after the spike; consumer backpressure via ev_ready, full FIFO drops events and sets sticky overflow.
module lif_spike_logger
  import lif_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int WIN_LEN = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_spike,
  input  logic [V_W-1:0]    in_vout,
  input  logic              clear,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [TS_W-1:0]   ev_ts,
  output logic [V_W-1:0]    ev_vpre,
  output logic [RATE_W-1:0] rate_count,
  output logic              rate_valid,
  output logic              overflow,
  output logic [1:0]        state
);
  localparam logic [WCNT_W-1:0] WIN_LAST = WCNT_W'(WIN_LEN - 1);

  lif_state_t        cur_st, nxt_st;
  logic [TS_W-1:0]   ts_cnt;
  logic [V_W-1:0]    prev_v;
  logic [WCNT_W-1:0] win_cnt, win_spk;
  logic [WCNT_W:0]   win_total;
  logic              push, pop, ev_drop, fifo_full, fifo_empty;
  spike_ev_t         wr_ev, rd_ev;

  assign push      = in_valid && in_spike && !clear;
  assign pop       = ev_ready && !clear;
  assign ev_drop   = push && fifo_full && !pop;
  assign wr_ev     = '{ts: ts_cnt, vpre: prev_v};
  assign win_total = {1'b0, win_spk} + (WCNT_W+1)'(in_spike);

  spike_event_fifo #(.DEPTH(DEPTH), .W(EV_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .push_data (wr_ev),
    .pop       (pop),
    .head      (rd_ev),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign ev_ts    = rd_ev.ts;
  assign ev_vpre  = rd_ev.vpre;
  assign state    = cur_st;

  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      ST_IDLE:  if (in_valid) nxt_st = ST_RUN;
      ST_RUN:   if (!in_valid) nxt_st = ST_DRAIN;
      ST_DRAIN: if (in_valid) nxt_st = ST_RUN;
                else if (fifo_empty) nxt_st = ST_IDLE;
      default:  nxt_st = ST_IDLE;
    endcase
    if (clear) nxt_st = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_st <= ST_IDLE;
    else     cur_st <= nxt_st;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt     <= '0;
      prev_v     <= '0;
      win_cnt    <= '0;
      win_spk    <= '0;
      rate_count <= '0;
      rate_valid <= 1'b0;
      overflow   <= 1'b0;
    end else if (clear) begin
      ts_cnt     <= '0;
      prev_v     <= '0;
      win_cnt    <= '0;
      win_spk    <= '0;
      rate_count <= '0;
      rate_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      if (ev_drop) overflow <= 1'b1;
      if (in_valid) begin
        ts_cnt <= ts_cnt + TS_W'(1);
        // On a spike the neuron output holds its rest value, so keep the last live voltage.
        if (!in_spike) prev_v <= in_vout;
        if (win_cnt == WIN_LAST) begin
          rate_count <= sat_rate(win_total);
          rate_valid <= 1'b1;
          win_cnt    <= '0;
          win_spk    <= '0;
        end else begin
          win_cnt <= win_cnt + WCNT_W'(1);
          win_spk <= win_total[WCNT_W-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_lif_spike_logger.sv
// Directed self-checking bench for lif_spike_logger (DEPTH=8, WIN_LEN=4).
module tb_lif_spike_logger;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_spike, clear, ev_ready;
  logic [15:0] in_vout;
  logic        ev_valid, rate_valid, overflow;
  logic [15:0] ev_ts, ev_vpre;
  logic [7:0]  rate_count;
  logic [1:0]  state;
  int          n_pass = 0;
  int          n_checks = 0;

  lif_spike_logger #(.DEPTH(8), .WIN_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_spike   (in_spike),
    .in_vout    (in_vout),
    .clear      (clear),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_ts      (ev_ts),
    .ev_vpre    (ev_vpre),
    .rate_count (rate_count),
    .rate_valid (rate_valid),
    .overflow   (overflow),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear;
    clear = 1'b1; in_valid = 1'b0; in_spike = 1'b0; ev_ready = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 0; in_spike = 0; in_vout = '0; clear = 0; ev_ready = 0;
    #12;
    if (ev_valid !== 1'b0) $display("FAIL reset_ev_valid: got %0b want 0", ev_valid); else n_pass++; n_checks++;
    if (ev_ts !== 16'h0 || ev_vpre !== 16'h0) $display("FAIL reset_ev_data: got ts=%h vpre=%h want 0/0", ev_ts, ev_vpre); else n_pass++; n_checks++;
    if (rate_count !== 8'd0 || rate_valid !== 1'b0) $display("FAIL reset_rate: got %0d/%0b want 0/0", rate_count, rate_valid); else n_pass++; n_checks++;
    if (overflow !== 1'b0 || state !== 2'd0) $display("FAIL reset_ovf_state: got %0b/%0d want 0/0", overflow, state); else n_pass++; n_checks++;
    tick();
    rst = 1'b0;
    tick();
    if (state !== 2'd0) $display("FAIL reset_idle_hold: got %0d want 0", state); else n_pass++; n_checks++;
  endtask

  task automatic test_single_event;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1;
      in_spike = (i == 4);
      in_vout  = (i == 3) ? 16'h0A00 : (i == 4) ? 16'hE000 : 16'(i * 16'h0100);
      tick();
      if (i == 3) begin
        if (ev_valid !== 1'b0) $display("FAIL single_pre_spike_valid: got %0b want 0", ev_valid); else n_pass++; n_checks++;
      end
      if (i == 4) begin
        if (ev_valid !== 1'b1) $display("FAIL single_ev_valid: got %0b want 1", ev_valid); else n_pass++; n_checks++;
        if (ev_ts !== 16'd3) $display("FAIL single_ev_ts: got %h want 0003", ev_ts); else n_pass++; n_checks++;
        if (ev_vpre !== 16'h0A00) $display("FAIL single_ev_vpre: got %h want 0a00", ev_vpre); else n_pass++; n_checks++;
      end
    end
    if (ev_ts !== 16'd3 || ev_vpre !== 16'h0A00) $display("FAIL single_hold_stable: got ts=%h vpre=%h want 0003/0a00", ev_ts, ev_vpre); else n_pass++; n_checks++;
    if (state !== 2'd1) $display("FAIL single_state_run: got %0d want 1", state); else n_pass++; n_checks++;
    in_valid = 1'b0; in_spike = 1'b0; ev_ready = 1'b1;
    tick();
    if (ev_valid !== 1'b0 || ev_ts !== 16'h0 || ev_vpre !== 16'h0) $display("FAIL single_after_pop: got v=%0b ts=%h vpre=%h want 0/0/0", ev_valid, ev_ts, ev_vpre); else n_pass++; n_checks++;
    if (state !== 2'd2) $display("FAIL single_state_drain: got %0d want 2", state); else n_pass++; n_checks++;
    tick();
    if (state !== 2'd0 || ev_valid !== 1'b0) $display("FAIL single_state_idle: got st=%0d v=%0b want 0/0", state, ev_valid); else n_pass++; n_checks++;
    do_clear();
  endtask

  task automatic test_overflow;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_spike = 1'b1; ev_ready = 1'b0;
      tick();
      if (k == 7) begin
        if (overflow !== 1'b0 || ev_ts !== 16'd0) $display("FAIL ovf_at_full: got ovf=%0b head=%h want 0/0000", overflow, ev_ts); else n_pass++; n_checks++;
      end
      if (k == 8) begin
        if (overflow !== 1'b1) $display("FAIL ovf_ninth: got %0b want 1", overflow); else n_pass++; n_checks++;
      end
    end
    in_valid = 1'b0; in_spike = 1'b0; ev_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (ev_valid !== 1'b1 || ev_ts !== 16'(k)) $display("FAIL ovf_drain_%0d: got v=%0b ts=%h want 1/%h", k, ev_valid, ev_ts, 16'(k)); else n_pass++; n_checks++;
      tick();
    end
    if (ev_valid !== 1'b0 || overflow !== 1'b1) $display("FAIL ovf_after_drain: got v=%0b ovf=%0b want 0/1", ev_valid, overflow); else n_pass++; n_checks++;
    do_clear();
    if (overflow !== 1'b0 || state !== 2'd0) $display("FAIL clear_ovf_state: got ovf=%0b st=%0d want 0/0", overflow, state); else n_pass++; n_checks++;
  endtask

  task automatic test_full_push_pop;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_spike = 1'b1; ev_ready = 1'b0;
      tick();
    end
    if (ev_ts !== 16'd0) $display("FAIL fpp_head_before: got %h want 0000", ev_ts); else n_pass++; n_checks++;
    ev_ready = 1'b1;
    tick();
    if (ev_ts !== 16'd1 || overflow !== 1'b0) $display("FAIL fpp_simul: got head=%h ovf=%0b want 0001/0", ev_ts, overflow); else n_pass++; n_checks++;
    in_valid = 1'b0; in_spike = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (ev_valid !== 1'b1 || ev_ts !== 16'(k)) $display("FAIL fpp_drain_%0d: got v=%0b ts=%h want 1/%h", k, ev_valid, ev_ts, 16'(k)); else n_pass++; n_checks++;
      tick();
    end
    if (ev_valid !== 1'b0) $display("FAIL fpp_empty: got %0b want 0", ev_valid); else n_pass++; n_checks++;
    do_clear();
  endtask

  task automatic test_rate;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) begin
        in_valid = 1'b0; in_spike = 1'b1;
        tick();
      end
      in_valid = 1'b1; in_spike = (c == 1 || c == 3);
      tick();
      if (c == 2) begin
        if (rate_valid !== 1'b0) $display("FAIL rate_early: got %0b want 0", rate_valid); else n_pass++; n_checks++;
      end
      if (c == 3) begin
        if (rate_valid !== 1'b1 || rate_count !== 8'd2) $display("FAIL rate_win0: got %0b/%0d want 1/2", rate_valid, rate_count); else n_pass++; n_checks++;
      end
      if (c == 4) begin
        if (rate_valid !== 1'b0 || rate_count !== 8'd2) $display("FAIL rate_pulse_end: got %0b/%0d want 0/2", rate_valid, rate_count); else n_pass++; n_checks++;
      end
      if (c == 7) begin
        if (rate_valid !== 1'b1 || rate_count !== 8'd0) $display("FAIL rate_win1: got %0b/%0d want 1/0", rate_valid, rate_count); else n_pass++; n_checks++;
      end
    end
    do_clear();
  endtask

  task automatic test_wrap;
    in_valid = 1'b1; in_spike = 1'b0; in_vout = 16'h0100; ev_ready = 1'b0;
    repeat (16'hFFFE) tick();
    in_spike = 1'b1; in_vout = 16'hE000;
    repeat (3) tick();
    in_valid = 1'b0; in_spike = 1'b0; ev_ready = 1'b1;
    if (ev_ts !== 16'hFFFE || ev_vpre !== 16'h0100) $display("FAIL wrap_ev0: got ts=%h vpre=%h want fffe/0100", ev_ts, ev_vpre); else n_pass++; n_checks++;
    tick();
    if (ev_ts !== 16'hFFFF) $display("FAIL wrap_ev1: got %h want ffff", ev_ts); else n_pass++; n_checks++;
    tick();
    if (ev_valid !== 1'b1 || ev_ts !== 16'h0000) $display("FAIL wrap_ev2: got v=%0b ts=%h want 1/0000", ev_valid, ev_ts); else n_pass++; n_checks++;
    tick();
    do_clear();
  endtask

  task automatic test_drain_fsm;
    in_valid = 1'b1; in_spike = 1'b1; ev_ready = 1'b0;
    tick();
    if (state !== 2'd1) $display("FAIL fsm_run: got %0d want 1", state); else n_pass++; n_checks++;
    repeat (2) tick();
    in_valid = 1'b0; in_spike = 1'b0;
    tick();
    if (state !== 2'd2) $display("FAIL fsm_drain: got %0d want 2", state); else n_pass++; n_checks++;
    tick();
    if (state !== 2'd2) $display("FAIL fsm_drain_hold: got %0d want 2", state); else n_pass++; n_checks++;
    ev_ready = 1'b1;
    tick();
    tick();
    if (state !== 2'd2 || ev_valid !== 1'b1) $display("FAIL fsm_after_pop2: got st=%0d v=%0b want 2/1", state, ev_valid); else n_pass++; n_checks++;
    tick();
    if (ev_valid !== 1'b0) $display("FAIL fsm_after_pop3: got %0b want 0", ev_valid); else n_pass++; n_checks++;
    ev_ready = 1'b0;
    tick();
    if (state !== 2'd0) $display("FAIL fsm_idle: got %0d want 0", state); else n_pass++; n_checks++;

    in_valid = 1'b1; in_spike = 1'b1; in_vout = 16'h0300;
    repeat (3) tick();
    in_valid = 1'b0; in_spike = 1'b0;
    tick();
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    if (ev_valid !== 1'b1 || state !== 2'd2) $display("FAIL rst_precond: got v=%0b st=%0d want 1/2", ev_valid, state); else n_pass++; n_checks++;
    rst = 1'b1;
    #1;
    if (ev_valid !== 1'b0 || state !== 2'd0 || ev_ts !== 16'h0) $display("FAIL rst_async: got v=%0b st=%0d ts=%h want 0/0/0000", ev_valid, state, ev_ts); else n_pass++; n_checks++;
    #1;
    rst = 1'b0;
    in_valid = 1'b1; in_spike = 1'b1;
    tick();
    if (ev_valid !== 1'b1 || ev_ts !== 16'h0 || ev_vpre !== 16'h0) $display("FAIL rst_first_push: got v=%0b ts=%h vpre=%h want 1/0000/0000", ev_valid, ev_ts, ev_vpre); else n_pass++; n_checks++;
    in_valid = 1'b0; in_spike = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_overflow();
    test_full_push_pop();
    test_rate();
    test_wrap();
    test_drain_fsm();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/lif_spike_logger.md
LIF_SPIKE_LOGGER -- requirements
Module: lif_spike_logger

Interface
REQ-001 Parameter DEPTH, default 8, event FIFO entries (power of two, 2..16) SHALL be supported.
REQ-002 Parameter WIN_LEN, default 256, rate-window length in valid cycles (2..65535) SHALL be supported.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  high while neuron is in its run state; sample is live.
REQ-006 in_spike  in  1  neuron spike flag for current sample.
REQ-007 in_vout  in  16  neuron membrane voltage, signed fixed point (1,6,9).
REQ-008 clear  in  1  synchronous soft clear.
REQ-009 ev_valid  out  1  FIFO head holds an event.
REQ-010 ev_ready  in  1  consumer accepts head when ev_valid & ev_ready.
REQ-011 ev_ts  out  16  timestamp of head event.
REQ-012 ev_vpre  out  16  pre-spike voltage of head event.
REQ-013 rate_count  out  8  spikes counted in last completed window.
REQ-014 rate_valid  out  1  one-cycle pulse when rate_count updates.
REQ-015 overflow  out  1  sticky: an event was dropped.
REQ-016 state  out  2  FSM state, debug.

Function
REQ-017 FSM states SHALL be IDLE=0, RUN=1, DRAIN=2; IDLE->RUN when in_valid=1; RUN->DRAIN when in_valid=0; DRAIN->RUN when in_valid=1; DRAIN->IDLE when FIFO empty and in_valid=0.
REQ-018 Timestamp counter SHALL increment by 1 on every clock with in_valid=1, wrap 0xFFFF->0x0000, hold otherwise.
REQ-019 Event ts SHALL equal counter value before that cycle's increment.
REQ-020 prev_v register SHALL load in_vout on every in_valid=1 cycle without in_spike; an event SHALL capture prev_v (not in_vout, which holds E_REST on spike).
REQ-021 Push SHALL occur when in_valid=1 and in_spike=1; in_spike with in_valid=0 SHALL be ignored.
REQ-022 FIFO SHALL be first-word-fall-through: event pushed at edge N visible with ev_valid=1 after edge N (one-cycle latency); ev_ts/ev_vpre stable while ev_valid=1 and ev_ready=0.
REQ-023 Push when full and no pop SHALL drop the event and set overflow; push and pop in same cycle when full SHALL both succeed.
REQ-024 Pop when empty SHALL have no effect; ev_ts/ev_vpre SHALL read 0 when empty.
REQ-025 Window counter SHALL count in_valid cycles; on the WIN_LEN-th valid cycle rate_count SHALL load window spike total (including that cycle's spike), saturating at 255, rate_valid pulse next cycle, window counters restart at 0.
REQ-026 Spike counting SHALL be independent of FIFO drops.
REQ-027 clear SHALL, with priority over all other inputs, empty FIFO, zero timestamp, window counters, rate_count, prev_v, overflow, and force IDLE; it SHALL not pop/push that cycle.

Reset
REQ-028 rst SHALL asynchronously force: state=IDLE, FIFO empty, ev_valid=0, ev_ts=0, ev_vpre=0, rate_count=0, rate_valid=0, overflow=0, timestamp=0, prev_v=0.
REQ-029 Reset assertion mid-operation SHALL discard all buffered events; first push after deassertion SHALL carry ts=0.

Structure
REQ-030 Shared package lif_pkg SHALL hold the voltage width (16), fixed-point format constants, timestamp width, and the FSM state encoding.
REQ-031 FIFO SHALL be a separate sub-module spike_event_fifo (32-bit entries {ts, vpre}, DEPTH parameter, full/empty, async reset).

Verification
REQ-032 Reset, in_valid=1 for 10 cycles, spike at cycle 4 with in_vout cycle 3=0x0A00 -> one event ts=3, vpre=0x0A00, ev_valid one cycle after spike.
REQ-033 ev_ready=0, spike every valid cycle for 10 cycles, DEPTH=8 -> 8 events ts=0..7 retained, overflow=1 from 9th spike, then draining yields ts 0..7 in order.
REQ-034 FIFO full, simultaneous spike and ev_ready=1 -> pop ts of head, new event appended, overflow stays 0.
REQ-035 WIN_LEN=4, spikes on valid cycles 1 and 3 (0-based) -> rate_count=2, rate_valid single pulse; next window no spikes -> rate_count=0.
REQ-036 Preload timestamp to 0xFFFE via 0xFFFE valid cycles, spikes next 3 cycles -> events ts=0xFFFE, 0xFFFF, 0x0000.
REQ-037 3 events buffered, in_valid falls -> state RUN->DRAIN, stays DRAIN until third pop, then IDLE; rst asserted mid-drain -> ev_valid=0 immediately.
